// File: rtl/spike_count_decoder.sv
// Spike-count classifier: accumulates per-class saturating spike counts over a
// fixed window, then scans them sequentially for the argmax (lowest index wins ties).
module spike_count_decoder_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i)              cnt_q <= '0;
    else if (inc_i && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module spike_count_decoder #(
  parameter int NUM_CLASSES = 10,
  parameter int T_STEPS     = 25,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   spike_valid,
  input  logic [NUM_CLASSES-1:0] spikes,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       class_idx,
  output logic [CNT_W-1:0]       class_count,
  output logic                   tie
);
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_e;

  localparam logic [7:0]     LAST_STEP = 8'(T_STEPS - 1);
  localparam logic [IDX_W:0] SCAN_END  = (IDX_W+1)'(NUM_CLASSES);

  state_e                              state_q;
  logic [7:0]                          step_q;
  logic [IDX_W:0]                      scan_q;
  logic [IDX_W-1:0]                    best_idx_q;
  logic [CNT_W-1:0]                    best_cnt_q;
  logic                                best_tie_q;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]                    cur_cnt;
  logic                                acc_en, clr;

  assign acc_en = (state_q == ACCUM) && spike_valid;
  assign clr    = (state_q == IDLE) && start;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
    spike_count_decoder_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr),
      .inc_i (acc_en && spikes[g]),
      .cnt_o (cnt[g])
    );
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (scan_q == (IDX_W+1)'(i)) cur_cnt = cnt[i];
  end

  // Scan covers j=0..N-1, then one extra SCAN cycle publishes the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      best_tie_q   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_count  <= '0;
      tie          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          step_q  <= '0;
          busy    <= 1'b1;
          state_q <= ACCUM;
        end
        ACCUM: if (spike_valid) begin
          step_q <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            scan_q  <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (scan_q == SCAN_END) begin
            class_idx    <= best_idx_q;
            class_count  <= best_cnt_q;
            tie          <= best_tie_q;
            result_valid <= 1'b1;
            state_q      <= DONE;
          end else begin
            if (scan_q == '0) begin
              best_idx_q <= '0;
              best_cnt_q <= cur_cnt;
              best_tie_q <= 1'b0;
            end else if (cur_cnt > best_cnt_q) begin
              best_idx_q <= scan_q[IDX_W-1:0];
              best_cnt_q <= cur_cnt;
              best_tie_q <= 1'b0;
            end else if (cur_cnt == best_cnt_q) begin
              best_tie_q <= 1'b1;
            end
            scan_q <= scan_q + 1'b1;
          end
        end
        DONE: if (result_ready) begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spike_count_decoder.sv
// Scoreboard bench: two decoders (8-bit and 4-bit counters) share stimulus;
// expected results are queued at drive time and popped when result_valid rises.
module tb_spike_count_decoder;
  localparam int NC = 10;
  localparam int T  = 25;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] cnt;
    logic       tie;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, spike_valid, result_ready;
  logic [NC-1:0] spikes;
  logic          busy8, rv8, tie8, busy4, rv4, tie4;
  logic [3:0]    idx8, idx4;
  logic [7:0]    cnt8;
  logic [3:0]    cnt4;

  logic [NC-1:0] pat [T];
  exp_t          q8[$], q4[$];
  int            nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  spike_count_decoder #(.NUM_CLASSES(NC), .T_STEPS(T), .CNT_W(8), .IDX_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .spike_valid(spike_valid), .spikes(spikes),
    .result_ready(result_ready), .busy(busy8), .result_valid(rv8), .class_idx(idx8),
    .class_count(cnt8), .tie(tie8));

  spike_count_decoder #(.NUM_CLASSES(NC), .T_STEPS(T), .CNT_W(4), .IDX_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .spike_valid(spike_valid), .spikes(spikes),
    .result_ready(result_ready), .busy(busy4), .result_valid(rv4), .class_idx(idx4),
    .class_count(cnt4), .tie(tie4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: max count, first index holding it, tie if more than one holds it.
  function automatic exp_t model(input int w);
    int   c [NC];
    int   mx, lim, nmax;
    exp_t e;
    lim = (1 << w) - 1;
    for (int i = 0; i < NC; i++) c[i] = 0;
    for (int s = 0; s < T; s++)
      for (int i = 0; i < NC; i++)
        if (pat[s][i] && c[i] < lim) c[i]++;
    mx = 0;
    for (int i = 0; i < NC; i++) if (c[i] > mx) mx = c[i];
    nmax = 0;
    e.idx = '0;
    for (int i = NC - 1; i >= 0; i--)
      if (c[i] == mx) begin
        e.idx = 4'(i);
        nmax++;
      end
    e.cnt = 8'(mx);
    e.tie = (nmax > 1);
    return e;
  endfunction

  task automatic clr_pat();
    for (int s = 0; s < T; s++) pat[s] = '0;
  endtask

  task automatic run_window(input string nm, input bit gaps, input bit mid_start, input int bp);
    int   lat;
    exp_t e8, e4;
    q8.push_back(model(8));
    q4.push_back(model(4));
    result_ready = (bp == 0);
    start = 1'b1; spike_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < T; s++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          spike_valid = 1'b0;
          spikes      = NC'($urandom);
          start       = mid_start && (s == 10);
          @(negedge clk);
        end
      end
      spike_valid = 1'b1;
      spikes      = pat[s];
      start       = mid_start && (s == 12);
      @(negedge clk);
    end
    spike_valid = 1'b0; start = 1'b0; spikes = NC'($urandom);
    lat = 0;
    while (!rv8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk({nm, "_timeout"}, 32'(lat), 0);
    if (!gaps) chk({nm, "_lat"}, 32'(lat), 11);
    e8 = q8.pop_front();
    e4 = q4.pop_front();
    chk({nm, "_rv4"},  32'(rv4), 1);
    chk({nm, "_busy"}, 32'(busy8), 1);
    chk({nm, "_idx8"}, 32'(idx8), 32'(e8.idx));
    chk({nm, "_cnt8"}, 32'(cnt8), 32'(e8.cnt));
    chk({nm, "_tie8"}, 32'(tie8), 32'(e8.tie));
    chk({nm, "_idx4"}, 32'(idx4), 32'(e4.idx));
    chk({nm, "_cnt4"}, 32'(cnt4), 32'(e4.cnt));
    chk({nm, "_tie4"}, 32'(tie4), 32'(e4.tie));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk({nm, "_bp_rv"},  32'(rv8), 1);
      chk({nm, "_bp_idx"}, 32'(idx8), 32'(e8.idx));
      chk({nm, "_bp_cnt"}, 32'(cnt8), 32'(e8.cnt));
      chk({nm, "_bp_tie"}, 32'(tie8), 32'(e8.tie));
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_rv_drop"},   32'(rv8), 0);
    chk({nm, "_busy_drop"}, 32'(busy8), 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; spike_valid = 1'b0; spikes = '0; result_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start = 1'($urandom); spike_valid = 1'($urandom);
      spikes = NC'($urandom); result_ready = 1'($urandom);
      @(negedge clk);
    end
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_rv",   32'(rv8), 0);
    chk("rst_idx",  32'(idx8), 0);
    chk("rst_cnt",  32'(cnt8), 0);
    chk("rst_tie",  32'(tie8), 0);
    reset = 1'b0; start = 1'b0; spike_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      spikes = NC'($urandom);
      @(negedge clk);
      if (rv8 || busy8) seen++;
    end
    chk("idle_no_result", 32'(seen), 0);
    spike_valid = 1'b0;

    // Class 3 every step, class 7 every other step.
    clr_pat();
    for (int s = 0; s < T; s++) begin
      pat[s][3] = 1'b1;
      pat[s][7] = (s % 2 == 0);
    end
    run_window("basic", 0, 0, 0);

    clr_pat();
    for (int s = 0; s < 10; s++) pat[s][2] = 1'b1;
    for (int s = 5; s < 15; s++) pat[s][5] = 1'b1;
    run_window("tie", 0, 0, 0);

    clr_pat();
    run_window("zero", 0, 0, 0);

    clr_pat();
    for (int s = 0; s < T; s++) begin
      pat[s][9] = 1'b1;
      pat[s][1] = (s < 12);
    end
    run_window("sat", 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < T; s++) pat[s] = NC'($urandom);
      run_window("gaps", 1, 1, (r == 0) ? 5 : 0);
    end

    // Abort after 12 accepted steps.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; spike_valid = 1'b1;
    for (int s = 0; s < 12; s++) begin
      spikes = NC'($urandom) | NC'(2);
      @(negedge clk);
    end
    reset = 1'b1; spike_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_rv",   32'(rv8), 0);
    chk("abort_idx",  32'(idx8), 0);
    chk("abort_cnt",  32'(cnt8), 0);
    chk("abort_tie",  32'(tie8), 0);

    clr_pat();
    for (int s = 0; s < T; s++) pat[s][0] = 1'b1;
    run_window("after_abort", 0, 0, 0);

    chk("queue_empty", 32'(q8.size() + q4.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
